updown_counter_param: RTL and testbench

- Parametrised synchronous up/down counter; successor to the fixed 4-bit up-only and down-only counters.
- Adds programmable width and modulus, runtime direction, parallel load, count enable, wrap or saturate mode, prescaled stepping, terminal-count pulse and sticky overflow/underflow flags.
- Used as a general event, timer or index counter inside datapath and control blocks.

---
 rtl/updown_counter_param_pkg.sv | 18 +
 rtl/updown_counter_param_prescaler.sv | 41 ++++
 rtl/updown_counter_param.sv | 112 +++++++++++
 tb/tb_updown_counter_param.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_param_pkg.sv
// Shared constants and helpers for the parametrised up/down counter and its prescaler.
package updown_counter_param_pkg;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // A single-cycle prescaler still gets a 1-bit register so the port list stays uniform.
    function automatic int presc_width(input int prescale);
        if (prescale <= 1) begin
            return 1;
        end else begin
            return $clog2(prescale);
        end
    endfunction

endpackage

// File: rtl/updown_counter_param_prescaler.sv
// Step prescaler: issues one tick every PRESCALE enabled cycles; restart realigns the period.
module counter_prescaler
    import updown_counter_param_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int             PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_r;
    logic          hit_s;

    assign hit_s = (cnt_r == LAST);
    // A restart cycle is a load cycle in the parent, so it never produces a step.
    assign tick  = en & ~restart & hit_s;

    // Prescaler phase counter: advances on enabled cycles, wraps on a step, holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {PW{1'b0}};
        end else if (restart) begin
            cnt_r <= {PW{1'b0}};
        end else if (en) begin
            if (hit_s) begin
                cnt_r <= {PW{1'b0}};
            end else begin
                cnt_r <= cnt_r + PW'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate boundary, prescaled stepping,
// terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero,
    output logic             ovf,
    output logic             unf
);

    // Computed in 32-bit int before narrowing, so MODULUS == 2**WIDTH yields all ones.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             ovf_r;
    logic             unf_r;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic             tick_s;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (load),
        .tick    (tick_s)
    );

    // Next-count and boundary detection: load beats a step; boundaries never rely on overflow.
    always_comb begin
        q_nxt_s   = q_r;
        tc_nxt_s  = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (load) begin
            if (load_val > MAX_VAL) begin
                q_nxt_s = MAX_VAL;
            end else begin
                q_nxt_s = load_val;
            end
        end else if (tick_s) begin
            if (up == DIR_UP) begin
                if (q_r == MAX_VAL) begin
                    tc_nxt_s  = 1'b1;
                    ovf_set_s = 1'b1;
                    if (SATURATE == MODE_SAT) begin
                        q_nxt_s = q_r;
                    end else begin
                        q_nxt_s = {WIDTH{1'b0}};
                    end
                end else begin
                    q_nxt_s = q_r + WIDTH'(1'b1);
                end
            end else begin
                if (q_r == {WIDTH{1'b0}}) begin
                    tc_nxt_s  = 1'b1;
                    unf_set_s = 1'b1;
                    if (SATURATE == MODE_SAT) begin
                        q_nxt_s = q_r;
                    end else begin
                        q_nxt_s = MAX_VAL;
                    end
                end else begin
                    q_nxt_s = q_r - WIDTH'(1'b1);
                end
            end
        end else begin
            q_nxt_s = q_r;
        end
    end

    // State registers; a flag set in the same cycle as clr_flags survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= {WIDTH{1'b0}};
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            q_r   <= q_nxt_s;
            tc_r  <= tc_nxt_s;
            ovf_r <= ovf_set_s | (ovf_r & ~clr_flags);
            unf_r <= unf_set_s | (unf_r & ~clr_flags);
        end
    end

    assign q    = q_r;
    assign tc   = tc_r;
    assign ovf  = ovf_r;
    assign unf  = unf_r;
    assign zero = (q_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed self-checking bench: four counter configurations driven by shared stimulus.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       clr_flags = 1'b0;

    // a: mod-10 wrap, b: mod-10 saturate, c: mod-10 wrap prescale 3, d: mod-16 wrap
    logic [3:0] q_a, q_b, q_c, q_d;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       zero_a, zero_b, zero_c, zero_d;
    logic       ovf_a, ovf_b, ovf_c, ovf_d;
    logic       unf_a, unf_b, unf_c, unf_d;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .q(q_a), .tc(tc_a), .zero(zero_a), .ovf(ovf_a), .unf(unf_a));
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .q(q_b), .tc(tc_b), .zero(zero_b), .ovf(ovf_b), .unf(unf_b));
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .q(q_c), .tc(tc_c), .zero(zero_c), .ovf(ovf_c), .unf(unf_c));
    updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) dut_d (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .q(q_d), .tc(tc_d), .zero(zero_d), .ovf(ovf_d), .unf(unf_d));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it, so inputs change away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; clr_flags = 1'b0; load_val = 4'd0;
        step();
        rst = 1'b0;
    endtask

    int         exp_q;
    logic [3:0] presc_en [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int         presc_q  [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};

    initial begin
        #2;
        // Reset state
        do_reset();
        check_val("rst_q",    q_a,    0);
        check_val("rst_tc",   tc_a,   0);
        check_val("rst_ovf",  ovf_a,  0);
        check_val("rst_unf",  unf_a,  0);
        check_val("rst_zero", zero_a, 1);

        // Wrap up-count through the modulus boundary
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_val($sformatf("up_q_%0d", k),  q_a,  k % 10);
            check_val($sformatf("up_tc_%0d", k), tc_a, (k == 10) ? 1 : 0);
            check_val($sformatf("up_zero_%0d", k), zero_a, (k == 10) ? 1 : 0);
        end
        check_val("up_ovf", ovf_a, 1);
        check_val("up_unf", unf_a, 0);
        check_val("up_sat_hold", q_b, 9);
        check_val("up_d_q", q_d, 12);

        // Down-count from zero; first step coincides with clr_flags so the set must win
        do_reset();
        en = 1'b1; up = 1'b0; clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check_val("dn_q_1",   q_a,  9);
        check_val("dn_tc_1",  tc_a, 1);
        check_val("dn_unf_setwins", unf_a, 1);
        check_val("dn_d_q_1",  q_d, 15);
        check_val("dn_d_tc_1", tc_d, 1);
        check_val("dn_b_q_1",  q_b, 0);
        for (int k = 2; k <= 3; k++) begin
            step();
            check_val($sformatf("dn_q_%0d", k),  q_a,  10 - k);
            check_val($sformatf("dn_tc_%0d", k), tc_a, 0);
            check_val($sformatf("dn_d_q_%0d", k), q_d, 16 - k);
        end
        en = 1'b0; clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check_val("clr_unf", unf_a, 0);
        check_val("clr_hold_q", q_a, 7);

        // Full-range modulus: 15 -> 0 must wrap and flag overflow
        load = 1'b1; load_val = 4'd15;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check_val("d_wrap_q",   q_d,   0);
        check_val("d_wrap_tc",  tc_d,  1);
        check_val("d_wrap_ovf", ovf_d, 1);

        // Saturate mode at the upper boundary
        do_reset();
        load = 1'b1; load_val = 4'd8;
        step();
        check_val("sat_load_q", q_b, 8);
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_val($sformatf("sat_q_%0d", k),  q_b,  9);
            check_val($sformatf("sat_tc_%0d", k), tc_b, (k >= 2) ? 1 : 0);
        end
        check_val("sat_ovf", ovf_b, 1);
        up = 1'b0;
        step();
        check_val("sat_dn_q",  q_b,  8);
        check_val("sat_dn_tc", tc_b, 0);
        check_val("wrap_cmp_q", q_a, 0);

        // Load clamp and load-over-step priority
        load = 1'b1; load_val = 4'd13; en = 1'b0;
        step();
        check_val("clamp_a", q_a, 9);
        check_val("clamp_b", q_b, 9);
        check_val("clamp_d", q_d, 13);
        load_val = 4'd3; en = 1'b1; up = 1'b1;
        step();
        load = 1'b0; en = 1'b0;
        check_val("load_wins_q",  q_a,  3);
        check_val("load_wins_tc", tc_a, 0);

        // Prescale 3 with an enable gap mid-period
        do_reset();
        up = 1'b1;
        for (int k = 0; k < 11; k++) begin
            en = presc_en[k][0];
            step();
            check_val($sformatf("presc_q_%0d", k + 1),  q_c,  presc_q[k]);
            check_val($sformatf("presc_tc_%0d", k + 1), tc_c, 0);
        end
        en = 1'b0;

        // Reset mid-count overrides everything
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 16; k++) step();
        exp_q = 6;
        check_val("pre_rst_q",   q_a,   exp_q);
        check_val("pre_rst_ovf", ovf_a, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mid_rst_q",    q_a,    0);
        check_val("mid_rst_tc",   tc_a,   0);
        check_val("mid_rst_ovf",  ovf_a,  0);
        check_val("mid_rst_unf",  unf_a,  0);
        check_val("mid_rst_zero", zero_a, 1);

        // Reset at a would-be boundary step suppresses tc
        en = 1'b0; load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; en = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b0;
        check_val("rst_bnd_q",   q_a,   0);
        check_val("rst_bnd_tc",  tc_a,  0);
        check_val("rst_bnd_ovf", ovf_a, 0);

        // Reset together with load
        load = 1'b1; load_val = 4'd5;
        step();
        check_val("pre_rl_q", q_a, 5);
        rst = 1'b1; load_val = 4'd7;
        step();
        rst = 1'b0; load = 1'b0;
        check_val("rst_load_q",    q_a,    0);
        check_val("rst_load_zero", zero_a, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
